// File: rtl/x_delay_decode_pkg.sv
// Shared constants, state encoding and helpers for the delay-line TDC decoder.
package x_delay_pkg;

    localparam int DL_WIDTH = 32;
    localparam int POS_W    = 6;

    // Odd taps come from inverting stages, so they read back inverted.
    localparam logic [DL_WIDTH-1:0] ALT_MASK = 32'hAAAA_AAAA;
    localparam logic [POS_W-1:0]    POS_NONE = 6'd32;
    localparam logic [POS_W-1:0]    POS_MAX  = 6'd63;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/x_delay_decode_if.sv
// Snapshot, control and result-handshake bundle of the delay-line decoder.
interface x_delay_decode_if #(
    parameter int ACC_W = 14
);
    logic [31:0]      i_data;
    logic             i_start;
    logic             o_busy;
    logic [5:0]       o_pos;
    logic             o_valid;
    logic             i_ready;
    logic [ACC_W-1:0] o_sum;
    logic [5:0]       o_min;
    logic [5:0]       o_max;

    modport master (
        output i_data, i_start, i_ready,
        input  o_busy, o_pos, o_valid, o_sum, o_min, o_max
    );

    modport slave (
        input  i_data, i_start, i_ready,
        output o_busy, o_pos, o_valid, o_sum, o_min, o_max
    );
endinterface

// File: rtl/x_delay_decode_pos_enc.sv
// Combinational edge locator: tap normalisation, optional bubble filter
// (X_DELAY_DECODE_MAJ_EN) and priority encode of the first transition.
module x_delay_pos_enc
    import x_delay_pkg::*;
(
    input  logic [DL_WIDTH-1:0] i_data,
    output logic [POS_W-1:0]    o_pos
);

    logic [DL_WIDTH-1:0] norm_s;
    logic [DL_WIDTH-1:0] filt_s;
    logic [POS_W-1:0]    pos_s;

    // Normalise taps and optionally remove single-tap bubbles.
    always_comb begin
        norm_s = i_data ^ ALT_MASK;
        filt_s = norm_s;
`ifdef X_DELAY_DECODE_MAJ_EN
        for (int i = 1; i < DL_WIDTH - 1; i++) begin
            filt_s[i] = maj3(norm_s[i-1], norm_s[i], norm_s[i+1]);
        end
`else
        filt_s = norm_s;
`endif
    end

    // Scan from the top down so the lowest differing tap wins.
    always_comb begin
        pos_s = POS_NONE;
        for (int i = DL_WIDTH - 1; i >= 1; i--) begin
            pos_s = (filt_s[i] != filt_s[0]) ? POS_W'(i) : pos_s;
        end
    end

    assign o_pos = pos_s;

endmodule

// File: rtl/x_delay_decode.sv
// Delay-line TDC back-end: registered edge position plus N_SAMPLES
// sum/min/max measurement returned over valid/ready. Option: X_DELAY_DECODE_MAJ_EN.
module x_delay_decode
    import x_delay_pkg::*;
#(
    parameter int N_SAMPLES = 16,
    parameter int CNT_W     = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    x_delay_decode_if.slave bus
);

    localparam int ACC_W = POS_W + CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

    logic [POS_W-1:0] pos_s;
    logic [POS_W-1:0] pos_r;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [ACC_W-1:0] sum_r;
    logic [POS_W-1:0] min_r;
    logic [POS_W-1:0] max_r;
    logic             busy_r;
    logic             valid_r;

    x_delay_pos_enc u_pos_enc (
        .i_data (bus.i_data),
        .o_pos  (pos_s)
    );

    // Live edge position, one cycle behind the snapshot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pos_r <= 6'd0;
        end else begin
            pos_r <= pos_s;
        end
    end

    // Measurement FSM with accumulators and result handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            sum_r   <= '0;
            min_r   <= 6'd0;
            max_r   <= 6'd0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.i_start) begin
                        state_r <= CAPT;
                        busy_r  <= 1'b1;
                        cnt_r   <= '0;
                        sum_r   <= '0;
                        min_r   <= POS_MAX;
                        max_r   <= 6'd0;
                    end
                end
                CAPT: begin
                    // pos_r here is the snapshot taken while i_start was high.
                    sum_r <= sum_r + {{(ACC_W-POS_W){1'b0}}, pos_r};
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (pos_r < min_r) begin
                        min_r <= pos_r;
                    end
                    if (pos_r > max_r) begin
                        max_r <= pos_r;
                    end
                    if (cnt_r == CNT_LAST) begin
                        state_r <= DONE;
                        valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (valid_r && bus.i_ready) begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_pos   = pos_r;
    assign bus.o_busy  = busy_r;
    assign bus.o_valid = valid_r;
    assign bus.o_sum   = sum_r;
    assign bus.o_min   = min_r;
    assign bus.o_max   = max_r;

endmodule

// File: doc/x_delay_decode.md
Name: x_delay_decode

Overview:
Reader for the 32-tap delay-line snapshot bus (two-flop synchronised, one snapshot per i_clk). Normalises the alternating-polarity inverter taps to a thermometer code and locates the first transition (edge position). On request, accumulates N_SAMPLES positions into sum/min/max and returns them over a valid/ready handshake. Forms the measurement back-end of the delay-line TDC.

Parameters:
N_SAMPLES, 16, samples per measurement; legal range 1..255
CNT_W, 8, sample counter width; must satisfy 2^CNT_W > N_SAMPLES
ACC_W, POS_W+CNT_W (localparam), sum width = 14; never overflows

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; asynchronous, active-high
i_data  in  32  delay-line snapshot, new value every cycle
i_start  in  1  begin a measurement; sampled in IDLE only
o_busy  out  1  high in CAPT and DONE
o_pos  out  6  registered edge position of the previous cycle's i_data, live every cycle
o_valid  out  1  result available
i_ready  in  1  consumer accepts result
o_sum  out  ACC_W  sum of N_SAMPLES positions
o_min  out  6  minimum position
o_max  out  6  maximum position

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. Asserting i_rst at any time aborts any measurement in progress; no partial result is produced.
- Normalise: n[i] = i_data[i] ^ ALT_MASK[i], with ALT_MASK = 32'hAAAAAAAA (odd taps inverted).
- Position: lowest i in 1..31 with n[i] != n[0]; if none, 32. Range is 1..32, so 0 never occurs after reset. Encoding is combinational; o_pos is registered, giving 1-cycle latency.
- FSM states: IDLE, CAPT, DONE.
- IDLE: when i_start=1 at cycle T, go to CAPT at T+1 and initialise sum=0, min=63, max=0, cnt=0.
- CAPT: each cycle add o_pos to sum, update min/max, and increment cnt. The first sample accumulated is the i_data from cycle T. After N_SAMPLES accumulations, go to DONE. o_valid rises at T+N_SAMPLES+1.
- DONE: o_valid=1; o_sum/o_min/o_max are held stable. When o_valid & i_ready, go to IDLE next cycle and drop o_valid. i_ready may be held high beforehand; acceptance takes a single cycle.
- i_start is ignored in CAPT and DONE, including the handshake cycle.
- Outputs hold their last values in IDLE; they are guaranteed meaningful only while o_valid=1.
- No saturation logic is needed: the worst-case sum is 32*255 = 8160, which fits in 14 bits.

Optional Feature:
X_DELAY_DECODE_MAJ_EN
- Defined: bubble filter applied before position encoding. For i = 1..30, m[i] = majority(n[i-1], n[i], n[i+1]); m[0] = n[0] and m[31] = n[31]. Position is then computed on m. This adds no latency.
- Undefined: position is computed on n directly.

Decomposition:
- Package x_delay_pkg: DL_WIDTH=32, POS_W=6, ALT_MASK, POS_NONE=6'd32, and the state enum typedef.
- Sub-module x_delay_pos_enc, purely combinational: normalise, optional majority filter, priority encode to POS_W. The top module holds the o_pos register, FSM, counter, accumulators and handshake.

Test Plan:
1. i_data=32'hAAAAAA55 constant (n=0x000000FF), N_SAMPLES=16, start, i_ready=1 -> o_pos=8; o_valid at start+17 cycles; sum=128, min=8, max=8.
2. i_data=32'hAAAAAAAA and 32'h55555555 (no transition) -> o_pos=32 each. 16 samples of 32'hAAAAAAAA -> sum=512, min=max=32.
3. Alternate 32'hAAAAAA55 (pos 8) and 32'hAAAAA555 (n=0xFFF, pos 12) for 16 samples -> sum=160, min=8, max=12.
4. i_ready=0 for 5 cycles after o_valid -> o_valid and results stable; i_start pulses ignored; handshake returns to IDLE; a new start then works.
5. Assert i_rst mid-CAPT (cnt=7) -> all outputs 0 immediately, IDLE; no o_valid follows.
6. i_data=32'hAAAAAA5D (n=0xF7, bubble at bit 3) -> o_pos=3 without the macro; o_pos=8 with X_DELAY_DECODE_MAJ_EN.
